// File: rtl/stall_ctrl_pkg.sv
// Shared constants for the pipeline stall sequencer: stall masks, stall bit indices and
// FSM state encodings.
package stall_ctrl_pkg;

    localparam logic [3:0] STALL_NONE = 4'b0000;
    localparam logic [3:0] STALL_ID   = 4'b0011;
    localparam logic [3:0] STALL_EXE  = 4'b0111;
    localparam logic [3:0] STALL_MEM  = 4'b1111;

    localparam int unsigned STALL_PC     = 0;
    localparam int unsigned STALL_IFID   = 1;
    localparam int unsigned STALL_IDEXE  = 2;
    localparam int unsigned STALL_EXEMEM = 3;

    typedef enum logic [1:0] {
        D_IDLE = 2'd0,
        D_BUSY = 2'd1,
        D_DONE = 2'd2
    } div_state_e;

    typedef enum logic {
        M_IDLE = 1'b0,
        M_WAIT = 1'b1
    } mem_state_e;

endpackage

// File: rtl/stall_ctrl_timer.sv
// Loadable down-counter with zero flag; used for the divide length and the memory timeout.
module stall_timer #(
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/stall_ctrl.sv
// Pipeline stall sequencer: merges load-use, divider and memory-wait stalls into one
// stall vector, times out stuck memory accesses and counts PC-stall cycles.
module stall_ctrl
    import stall_ctrl_pkg::*;
#(
    parameter int unsigned DIV_CYCLES  = 32,
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        stallreq_id,
    input  logic        div_start,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic [3:0]  stall,
    output logic        div_busy,
    output logic        div_done,
    output logic        mem_err,
    output logic [31:0] stall_cnt
);

    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 2);
    localparam logic [CNT_W-1:0] MEM_LOAD = CNT_W'(MEM_TIMEOUT - 2);

    div_state_e  div_state_q, div_state_d;
    mem_state_e  mem_state_q, mem_state_d;
    logic        div_load, div_dec, dcnt_zero;
    logic        mem_load, mem_dec, mcnt_zero;
    logic        id_stall, exe_stall, mem_stall;
    logic [31:0] stall_cnt_q;

    always_comb begin
        div_state_d = div_state_q;
        mem_state_d = mem_state_q;
        div_load    = 1'b0;
        div_dec     = 1'b0;
        mem_load    = 1'b0;
        mem_dec     = 1'b0;
        exe_stall   = 1'b0;
        mem_stall   = 1'b0;
        div_done    = 1'b0;
        mem_err     = 1'b0;
        id_stall    = stallreq_id;

        unique case (mem_state_q)
            M_IDLE: begin
                if (mem_req && !mem_ready) begin
                    mem_stall   = 1'b1;
                    mem_load    = 1'b1;
                    mem_state_d = M_WAIT;
                end
            end
            M_WAIT: begin
                if (mem_ready) begin
                    mem_state_d = M_IDLE;
                end else if (!mcnt_zero) begin
                    mem_stall = 1'b1;
                    mem_dec   = 1'b1;
                end else begin
                    mem_err     = 1'b1;
                    mem_state_d = M_IDLE;
                end
            end
            default: mem_state_d = M_IDLE;
        endcase

        // The divider keeps counting while MEM holds the pipe; only the hand-off waits.
        unique case (div_state_q)
            D_IDLE: begin
                if (div_start) begin
                    exe_stall   = 1'b1;
                    div_load    = 1'b1;
                    div_state_d = D_BUSY;
                end
            end
            D_BUSY: begin
                exe_stall = 1'b1;
                if (dcnt_zero) begin
                    div_state_d = D_DONE;
                end else begin
                    div_dec = 1'b1;
                end
            end
            D_DONE: begin
                if (!mem_stall) begin
                    div_done    = 1'b1;
                    div_state_d = D_IDLE;
                end
            end
            default: div_state_d = D_IDLE;
        endcase

        if (flush || rst) begin
            div_state_d = D_IDLE;
            mem_state_d = M_IDLE;
            div_load    = 1'b0;
            div_dec     = 1'b0;
            mem_load    = 1'b0;
            mem_dec     = 1'b0;
            id_stall    = 1'b0;
            exe_stall   = 1'b0;
            mem_stall   = 1'b0;
            div_done    = 1'b0;
            mem_err     = 1'b0;
        end

        stall = (id_stall  ? STALL_ID  : STALL_NONE) |
                (exe_stall ? STALL_EXE : STALL_NONE) |
                (mem_stall ? STALL_MEM : STALL_NONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_state_q <= D_IDLE;
            mem_state_q <= M_IDLE;
            stall_cnt_q <= '0;
        end else begin
            div_state_q <= div_state_d;
            mem_state_q <= mem_state_d;
            if (stall[STALL_PC] && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    stall_timer #(
        .CNT_W(CNT_W)
    ) u_div_timer (
        .clk      (clk),
        .rst      (rst),
        .clr      (flush),
        .load     (div_load),
        .load_val (DIV_LOAD),
        .dec      (div_dec),
        .zero     (dcnt_zero)
    );

    stall_timer #(
        .CNT_W(CNT_W)
    ) u_mem_timer (
        .clk      (clk),
        .rst      (rst),
        .clr      (flush),
        .load     (mem_load),
        .load_val (MEM_LOAD),
        .dec      (mem_dec),
        .zero     (mcnt_zero)
    );

    assign div_busy  = (div_state_q != D_IDLE);
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_stall_ctrl.sv
// Directed bench for stall_ctrl with DIV_CYCLES=4, MEM_TIMEOUT=8.
module tb_stall_ctrl;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        stallreq_id;
    logic        div_start;
    logic        mem_req;
    logic        mem_ready;
    logic [3:0]  stall;
    logic        div_busy;
    logic        div_done;
    logic        mem_err;
    logic [31:0] stall_cnt;

    int checks;
    int errors;

    stall_ctrl #(
        .DIV_CYCLES  (4),
        .MEM_TIMEOUT (8),
        .CNT_W       (6)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .stallreq_id (stallreq_id),
        .div_start   (div_start),
        .mem_req     (mem_req),
        .mem_ready   (mem_ready),
        .stall       (stall),
        .div_busy    (div_busy),
        .div_done    (div_done),
        .mem_err     (mem_err),
        .stall_cnt   (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change just after the rising edge; outputs are sampled on the falling edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        flush       = 1'b0;
        stallreq_id = 1'b0;
        div_start   = 1'b0;
        mem_req     = 1'b0;
        mem_ready   = 1'b0;
    endtask

    task automatic test_reset();
        rst         = 1'b1;
        clear_inputs();
        stallreq_id = 1'b1;
        mem_req     = 1'b1;
        div_start   = 1'b1;
        @(negedge clk);
        checks++;
        if (stall !== 4'b0000) begin
            errors++;
            $display("FAIL reset_stall: got %b want 0000", stall);
        end
        checks++;
        if (stall_cnt !== 32'd0 || div_busy !== 1'b0 || div_done !== 1'b0 || mem_err !== 1'b0)
        begin
            errors++;
            $display("FAIL reset_outs: cnt=%0d busy=%b done=%b err=%b want 0 0 0 0",
                     stall_cnt, div_busy, div_done, mem_err);
        end
        next_cycle();
        rst = 1'b0;
        clear_inputs();
        @(negedge clk);
        checks++;
        if (stall !== 4'b0000 || stall_cnt !== 32'd0) begin
            errors++;
            $display("FAIL reset_release: stall=%b cnt=%0d want 0000 0", stall, stall_cnt);
        end
    endtask

    task automatic test_id();
        next_cycle();
        stallreq_id = 1'b1;
        @(negedge clk);
        checks++;
        if (stall !== 4'b0011 || stall_cnt !== 32'd0) begin
            errors++;
            $display("FAIL id_stall: stall=%b cnt=%0d want 0011 0", stall, stall_cnt);
        end
        next_cycle();
        stallreq_id = 1'b0;
        mem_req     = 1'b1;
        mem_ready   = 1'b1;
        @(negedge clk);
        checks++;
        if (stall !== 4'b0000 || stall_cnt !== 32'd1) begin
            errors++;
            $display("FAIL id_release: stall=%b cnt=%0d want 0000 1", stall, stall_cnt);
        end
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_div();
        logic [3:0] exp_stall;
        div_start = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            exp_stall = (c <= 4) ? 4'b0111 : 4'b0000;
            @(negedge clk);
            checks++;
            if (stall !== exp_stall || div_done !== (c == 5) || div_busy !== (c >= 2)) begin
                errors++;
                $display("FAIL div_c%0d: stall=%b done=%b busy=%b want %b %b %b", c, stall,
                         div_done, div_busy, exp_stall, (c == 5), (c >= 2));
            end
            next_cycle();
        end
        div_start = 1'b0;
        @(negedge clk);
        checks++;
        if (div_busy !== 1'b0 || stall !== 4'b0000 || stall_cnt !== 32'd5) begin
            errors++;
            $display("FAIL div_idle: busy=%b stall=%b cnt=%0d want 0 0000 5", div_busy, stall,
                     stall_cnt);
        end
        next_cycle();
    endtask

    task automatic test_mem_ready();
        logic [3:0] exp_stall;
        mem_req = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            mem_ready = (c == 4);
            exp_stall = (c <= 3) ? 4'b1111 : 4'b0000;
            @(negedge clk);
            checks++;
            if (stall !== exp_stall || mem_err !== 1'b0) begin
                errors++;
                $display("FAIL memrdy_c%0d: stall=%b err=%b want %b 0", c, stall, mem_err,
                         exp_stall);
            end
            next_cycle();
        end
        clear_inputs();
        @(negedge clk);
        checks++;
        if (stall_cnt !== 32'd8) begin
            errors++;
            $display("FAIL memrdy_cnt: got %0d want 8", stall_cnt);
        end
        next_cycle();
    endtask

    task automatic test_mem_timeout();
        logic [3:0] exp_stall;
        mem_req = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            exp_stall = (c <= 7) ? 4'b1111 : 4'b0000;
            @(negedge clk);
            checks++;
            if (stall !== exp_stall || mem_err !== (c == 8)) begin
                errors++;
                $display("FAIL memto_c%0d: stall=%b err=%b want %b %b", c, stall, mem_err,
                         exp_stall, (c == 8));
            end
            next_cycle();
        end
        clear_inputs();
        @(negedge clk);
        checks++;
        if (mem_err !== 1'b0 || stall_cnt !== 32'd15) begin
            errors++;
            $display("FAIL memto_after: err=%b cnt=%0d want 0 15", mem_err, stall_cnt);
        end
        next_cycle();
    endtask

    task automatic test_overlap();
        logic [3:0] exp_stall;
        div_start = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            mem_req   = (c >= 3);
            mem_ready = (c == 7);
            exp_stall = (c <= 2) ? 4'b0111 : ((c <= 6) ? 4'b1111 : 4'b0000);
            @(negedge clk);
            checks++;
            if (stall !== exp_stall || div_done !== (c == 7) || mem_err !== 1'b0) begin
                errors++;
                $display("FAIL ovl_c%0d: stall=%b done=%b err=%b want %b %b 0", c, stall,
                         div_done, mem_err, exp_stall, (c == 7));
            end
            next_cycle();
        end
        clear_inputs();
        @(negedge clk);
        checks++;
        if (div_busy !== 1'b0 || stall_cnt !== 32'd21) begin
            errors++;
            $display("FAIL ovl_after: busy=%b cnt=%0d want 0 21", div_busy, stall_cnt);
        end
        next_cycle();
    endtask

    task automatic test_reset_mid_div();
        div_start = 1'b1;
        next_cycle();
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (stall !== 4'b0000 || div_busy !== 1'b0 || stall_cnt !== 32'd0) begin
            errors++;
            $display("FAIL rstmid: stall=%b busy=%b cnt=%0d want 0000 0 0", stall, div_busy,
                     stall_cnt);
        end
        next_cycle();
        rst = 1'b0;
        clear_inputs();
        @(negedge clk);
        checks++;
        if (stall !== 4'b0000 || div_busy !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_after: stall=%b busy=%b want 0000 0", stall, div_busy);
        end
        next_cycle();
    endtask

    task automatic test_flush();
        div_start = 1'b1;
        next_cycle();
        flush = 1'b1;
        @(negedge clk);
        checks++;
        if (stall !== 4'b0000 || div_done !== 1'b0 || div_busy !== 1'b1) begin
            errors++;
            $display("FAIL flush_cyc: stall=%b done=%b busy=%b want 0000 0 1", stall, div_done,
                     div_busy);
        end
        next_cycle();
        clear_inputs();
        @(negedge clk);
        checks++;
        if (div_busy !== 1'b0 || div_done !== 1'b0 || stall_cnt !== 32'd1) begin
            errors++;
            $display("FAIL flush_after: busy=%b done=%b cnt=%0d want 0 0 1", div_busy,
                     div_done, stall_cnt);
        end
        next_cycle();
    endtask

    task automatic test_all_sources();
        stallreq_id = 1'b1;
        div_start   = 1'b1;
        mem_req     = 1'b1;
        @(negedge clk);
        checks++;
        if (stall !== 4'b1111) begin
            errors++;
            $display("FAIL all_src: got %b want 1111", stall);
        end
        next_cycle();
        flush = 1'b1;
        @(negedge clk);
        checks++;
        if (stall !== 4'b0000 || mem_err !== 1'b0 || div_done !== 1'b0) begin
            errors++;
            $display("FAIL all_flush: stall=%b err=%b done=%b want 0000 0 0", stall, mem_err,
                     div_done);
        end
        next_cycle();
        clear_inputs();
        @(negedge clk);
        checks++;
        if (stall !== 4'b0000 || div_busy !== 1'b0 || stall_cnt !== 32'd2) begin
            errors++;
            $display("FAIL all_after: stall=%b busy=%b cnt=%0d want 0000 0 2", stall, div_busy,
                     stall_cnt);
        end
        next_cycle();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_id();
        test_div();
        test_mem_ready();
        test_mem_timeout();
        test_overlap();
        test_reset_mid_div();
        test_flush();
        test_all_sources();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
